// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder (with helper cell full_adder)
//  Description : Bit-serial WIDTH-bit adder. Operands are accepted over a
//                valid/ready handshake, added one bit per clock LSB first
//                through a single full_adder cell and a carry flip-flop, and
//                the sum/carry-out are presented over a second valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single-bit full adder: the only arithmetic element in the serial datapath.
// ----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   // Sum is the parity of the three inputs, carry is their majority.
   always_comb begin
      s_o = a_i ^ b_i ^ c_i;
      c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   end

endmodule

// ----------------------------------------------------------------------------
// Serial adder top level.
// ----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Bit counter only has to reach WIDTH-1.
   localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Control state
   state_t             state_q,     state_d;
   logic [c_CNT_W-1:0] count_q,     count_d;

   // Serial datapath
   logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q,    sum_sh_d;
   logic               carry_q,     carry_d;

   // Result holding registers
   logic [WIDTH-1:0]   sum_q,       sum_d;
   logic               cout_q,      cout_d;
   logic               out_valid_q, out_valid_d;

   // Full adder outputs and input handshake
   logic               fa_sum;
   logic               fa_carry;
   logic               accept;
   logic [WIDTH-1:0]   sum_shifted;

   // The one and only adder cell works on the current LSBs and the carry reg.
   full_adder u_fa (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .c_i (carry_q),
      .s_o (fa_sum),
      .c_o (fa_carry)
   );

   // Ready is combinational so it drops immediately while reset is asserted.
   assign in_ready    = rst_n && (state_q == IDLE);
   assign accept      = in_valid && in_ready;

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in place.
   assign sum_shifted = {fa_sum, sum_shifted_tail(sum_sh_q)};

   assign out_valid   = out_valid_q;
   assign sum         = sum_q;
   assign cout        = cout_q;

   // Drops the LSB of the partial sum so the new bit can be prepended.
   function automatic logic [WIDTH-2:0] sum_shifted_tail(input logic [WIDTH-1:0] v);
      return v[WIDTH-1:1];
   endfunction

   // Next-state and datapath update: every register holds unless its state acts.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_sh_d    = sum_sh_q;
      carry_d     = carry_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            // Operands are captured only here; later input changes are ignored.
            if (accept) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               count_d  = '0;
               sum_sh_d = '0;
               state_d  = RUN;
            end
         end

         RUN: begin
            // One bit per clock: shift operands right, collect sum bit at MSB.
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = sum_shifted;
            carry_d  = fa_carry;
            if (count_q == c_LAST) begin
               // Last bit: publish the completed word and final carry together.
               sum_d       = sum_shifted;
               cout_d      = fa_carry;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               count_d = count_q + c_CNT_W'(1);
            end
         end

         DONE: begin
            // Result stays on the outputs until the consumer takes it.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_sh_q    <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_sh_q    <= sum_sh_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Accepted operands push
//                an expected {cout,sum} (from plain a+b+cin) into a
//                scoreboard; a monitor pops and compares on every output
//                handshake and checks the accept-to-valid latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      int           acc;
   } exp_t;

   exp_t sb[$];
   logic ov_prev = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the number of the preceding posedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the result is simply the integer sum of the operands.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input int acc);
      exp_t         e;
      logic [W:0]   t;
      t     = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      e.s   = t[W-1:0];
      e.c   = t[W];
      e.acc = acc;
      return e;
   endfunction

   // Monitor: latency on each out_valid rise, value on each output handshake.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && !ov_prev) begin
         check("pending_at_valid", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0)
            check("latency_edge", 32'(cyc), 32'(sb[0].acc + W));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         check("pending_at_handshake", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 32'(sum), 32'(e.s));
            check("cout", 32'(cout), 32'(e.c));
         end
      end
      ov_prev = (out_valid === 1'b1);
   end

   // Drive one operand set (at a negedge) and wait for it to be accepted.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input bit keep, output int acc);
      int n;
      a        = ta;
      b        = tb_v;
      cin      = tc;
      in_valid = 1'b1;
      n        = 0;
      acc      = -1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", 32'(n < 100), 32'd1);
      if (n < 100) begin
         acc = cyc + 1;
         sb.push_back(model(ta, tb_v, tc, acc));
         @(negedge clk);
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout at t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int prev_acc;
      int n;

      // 1. Reset held for three edges with in_valid asserted.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 8'h12;
      b         = 8'h34;
      cin       = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_sum", 32'(sum), 32'h0);
         check("rst_cout", 32'(cout), 32'd0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);

      // 2 + 4. Basic add, then hold the result under backpressure.
      out_ready = 1'b0;
      send(8'h0F, 8'h01, 1'b0, 1'b0, acc);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_rise", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            a        = 8'h33;
            b        = 8'h33;
            cin      = 1'b0;
            in_valid = 1'b1;
         end
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_sum_held", 32'(sum), 32'h10);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_sum_kept", 32'(sum), 32'h10);
      check("bp_back_idle", 32'(in_ready), 32'd1);
      drain();

      // 3. Full carry ripple cases.
      send(8'hFF, 8'h00, 1'b1, 1'b0, acc);
      drain();
      send(8'hFF, 8'hFF, 1'b1, 1'b0, acc);
      drain();

      // 5. Reset after three RUN edges aborts the operation.
      send(8'hAA, 8'h55, 1'b1, 1'b0, acc);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      sb.delete();
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_sum", 32'(sum), 32'h0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_idle", 32'(in_ready), 32'd1);
      @(negedge clk);
      send(8'hA5, 8'h5A, 1'b0, 1'b0, acc);
      drain();

      // 6. Streaming random operands with both handshakes always asserted.
      prev_acc = -1;
      for (int i = 0; i < 200; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), 1'b1, acc);
         if (prev_acc >= 0)
            check("stream_spacing", 32'(acc - prev_acc), 32'(W + 2));
         prev_acc = acc;
      end
      in_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the single-bit full_adder cell: one full_adder instance plus a carry flip-flop, operand shift registers and a control FSM.
- Accepts an N-bit operand pair and carry-in over a valid/ready handshake.
- Processes one bit per clock, LSB first.
- Presents the N-bit sum and carry-out over a second valid/ready handshake.
- Area-minimal alternative to a ripple adder in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair (a, b, cin) valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset is sampled only on the rising edge of clk. rst_n low at an edge gives:
  - state=IDLE, out_valid=0, sum=0, cout=0;
  - carry reg=0, bit counter=0, operand shift regs=0.
- in_ready = rst_n && (state==IDLE). It is combinational and is 0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with in_valid && in_ready: latch a and b into shift regs, carry reg<=cin, count<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per edge:
  - full_adder inputs are a_sh[0], b_sh[0] and the carry reg.
  - Its sum bit shifts into sum_sh at the MSB (right shift); its carry output loads the carry reg.
  - a_sh and b_sh shift right; count increments.
  - On the edge where count==WIDTH-1: go to DONE, load sum<=final sum_sh value and cout<=final carry, and set out_valid<=1.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - sum and cout keep their last value after the handshake, until the next result or reset.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: with continuous in_valid and out_ready, accepting edges are WIDTH+2 edges apart (DONE->IDLE edge, then the IDLE accept edge).
- No overlap: in_valid is ignored in RUN and DONE, and the operand regs are not disturbed.
- Input values are sampled only on the accepting edge; later changes to a, b and cin have no effect.
- Carry is internal only; cout is updated only on the DONE transition.
- Reset during RUN or DONE:
  - abort; the next state is IDLE with all reset values;
  - no partial result is ever presented.
- Counter width is $clog2(WIDTH); count never exceeds WIDTH-1.
- Arithmetic: {cout,sum} equals a+b+cin exactly for all inputs, including all-ones operands with cin=1.

Test Plan (WIDTH=8):
1. Reset: hold rst_n low 3 edges with in_valid=1 -> in_ready=0 and out_valid=0 throughout, sum=8'h00, cout=0; in_ready=1 in the cycle after the reset is released.
2. Basic add: a=8'h0F, b=8'h01, cin=0 -> out_valid high exactly 8 edges after the accept edge, sum=8'h10, cout=0.
3. Full ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
4. Backpressure: after op 2 completes, hold out_ready=0 for 5 cycles and pulse in_valid with a=8'h33 -> out_valid stays 1, sum stays 8'h10, in_ready stays 0, and the new operands are not accepted; raising out_ready gives out_valid=0 on the next edge.
5. Reset mid-run: start a=8'hAA, b=8'h55, cin=1, drop rst_n for 1 edge after 3 RUN edges -> IDLE, out_valid=0, sum=0; then a=8'hA5, b=8'h5A, cin=0 -> sum=8'hFF, cout=0.
6. Streaming: in_valid=1 and out_ready=1 continuously with 200 random (a, b, cin) -> every result equals a+b+cin, and accept edges are spaced exactly 10 edges apart.
